// File: rtl/xm23_pkg.sv
// Constants and types shared by the XM23 CPU and its execution controller.
package xm23_pkg;

  localparam int unsigned XM23_ADDR_W  = 16;
  localparam int unsigned EXEC_STATE_W = 2;

  typedef enum logic [EXEC_STATE_W-1:0] {
    EX_HALT  = 2'd0,
    EX_STEP  = 2'd1,
    EX_RUN   = 2'd2,
    EX_BREAK = 2'd3
  } exec_state_t;

  function automatic logic exec_is_halted(input exec_state_t s);
    return (s == EX_HALT) || (s == EX_BREAK);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, counting debouncer and
// a single-cycle pulse on each accepted press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic RST,
  input  logic key_n,
  output logic level,
  output logic fall_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_s1, r_s2, r_hist;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level, r_fall, r_armed;
  logic             w_same, w_sat;

  assign w_same = (r_s2 == r_hist);
  assign w_sat  = (r_cnt == CNT_MAX);

  // r_cnt counts consecutive samples equal to r_hist. A fall is only reported
  // once a released level has been accepted, so a key held through reset
  // stays silent until it is let go and pressed again.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_hist  <= 1'b1;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_s1   <= key_n;
      r_s2   <= r_s1;
      r_hist <= r_s2;
      r_fall <= 1'b0;
      if (!w_same)
        r_cnt <= CNT_W'(1);
      else if (!w_sat)
        r_cnt <= r_cnt + 1'b1;
      if (w_sat) begin
        r_level <= r_hist;
        if (r_hist)
          r_armed <= 1'b1;
        if (r_level && !r_hist && r_armed)
          r_fall <= 1'b1;
      end
    end
  end

  assign level      = r_level;
  assign fall_pulse = r_fall;

endmodule

// File: rtl/xm23_exec_ctrl.sv
// XM23 run/step/breakpoint controller: gates the CPU clock enable from a
// debounced step key, a run switch and a single address breakpoint.
module xm23_exec_ctrl
  import xm23_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AW              = XM23_ADDR_W
) (
  input  logic                    CLOCK_50,
  input  logic                    RST,
  input  logic                    step_key,
  input  logic                    run_sw,
  input  logic                    bkpt_en,
  input  logic [AW-1:0]           bkpt_addr,
  input  logic [AW-1:0]           pc,
  input  logic                    instr_done,
  output logic                    cpu_ce,
  output logic [EXEC_STATE_W-1:0] state,
  output logic                    halted,
  output logic                    bkpt_hit
);

  logic        w_key_level, w_key_fall, w_press;
  logic [1:0]  r_run_sync;
  logic        w_run, w_bkpt_match;
  exec_state_t r_state, w_next;
  logic        r_cpu_ce, r_halted, r_bkpt_hit;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
    .CLOCK_50   (CLOCK_50),
    .RST        (RST),
    .key_n      (step_key),
    .level      (w_key_level),
    .fall_pulse (w_key_fall)
  );

  // The fall pulse always coincides with a low level; the AND keeps the two
  // debouncer outputs consistent by construction.
  assign w_press = w_key_fall & ~w_key_level;

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) r_run_sync <= '0;
    else     r_run_sync <= {r_run_sync[0], run_sw};
  end

  assign w_run        = r_run_sync[1];
  assign w_bkpt_match = bkpt_en && (pc == bkpt_addr);

  always_comb begin
    w_next = r_state;
    case (r_state)
      EX_HALT:  if (w_press) w_next = w_run ? EX_RUN : EX_STEP;
      EX_STEP:  if (instr_done) w_next = EX_HALT;
      EX_RUN: begin
        if (instr_done) begin
          if (w_bkpt_match) w_next = EX_BREAK;
          else if (!w_run)  w_next = EX_HALT;
        end
      end
      EX_BREAK: if (w_press) w_next = EX_STEP;
      default:  w_next = EX_HALT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_state    <= EX_HALT;
      r_cpu_ce   <= 1'b0;
      r_halted   <= 1'b1;
      r_bkpt_hit <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cpu_ce   <= (w_next == EX_STEP) || (w_next == EX_RUN);
      r_halted   <= exec_is_halted(w_next);
      r_bkpt_hit <= (w_next == EX_BREAK);
    end
  end

  assign state    = r_state;
  assign cpu_ce   = r_cpu_ce;
  assign halted   = r_halted;
  assign bkpt_hit = r_bkpt_hit;

endmodule

// File: doc/xm23_exec_ctrl.md
XM23_EXEC_CTRL -- requirements
Module: xm23_exec_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the number of stable samples needed to accept a key level (10 ms at 50 MHz).
REQ-002 SHALL have parameter AW, default 16, giving the PC/breakpoint address width.
REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port step_key, input, 1 bit: raw pushbutton, active-low, asynchronous to CLOCK_50.
REQ-006 SHALL have port run_sw, input, 1 bit: 1 = run mode, 0 = single-step mode; level, sampled through a 2-FF synchronizer.
REQ-007 SHALL have port bkpt_en, input, 1 bit: breakpoint compare enable.
REQ-008 SHALL have port bkpt_addr, input, AW bits: breakpoint address.
REQ-009 SHALL have port pc, input, AW bits: CPU program counter, valid in any cycle where instr_done=1.
REQ-010 SHALL have port instr_done, input, 1 bit: one-cycle CPU pulse marking an instruction retire; pc then holds the next-instruction address.
REQ-011 SHALL have port cpu_ce, output, 1 bit: CPU clock enable.
REQ-012 SHALL have port state, output, 2 bits: current controller state code.
REQ-013 SHALL have port halted, output, 1 bit: 1 in HALT or BREAK.
REQ-014 SHALL have port bkpt_hit, output, 1 bit: 1 while in BREAK.

Function
REQ-015 SHALL pass step_key through a 2-FF synchronizer, then through a debouncer whose output changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples; any differing sample SHALL restart the count.
REQ-016 SHALL generate press, a one-cycle pulse on each 1->0 transition of the debounced key; holding the key SHALL produce no further pulses.
REQ-017 SHALL implement states HALT=0, STEP=1, RUN=2, BREAK=3.
REQ-018 HALT SHALL hold cpu_ce=0. On press it SHALL go to RUN if synchronized run_sw=1, else to STEP.
REQ-019 STEP SHALL hold cpu_ce=1. On instr_done=1 it SHALL go to HALT, with cpu_ce=0 from the next cycle, giving exactly one retired instruction. press SHALL be ignored.
REQ-020 RUN SHALL hold cpu_ce=1. On instr_done=1 with bkpt_en=1 and pc==bkpt_addr it SHALL go to BREAK. Otherwise, on instr_done=1 with run_sw=0 it SHALL go to HALT. press SHALL be ignored.
REQ-021 When instr_done=1 in RUN, breakpoint match and run_sw=0 both true: BREAK SHALL win.
REQ-022 A run_sw fall SHALL never stop the CPU mid-instruction; the state SHALL leave RUN only on an instr_done cycle.
REQ-023 BREAK SHALL hold cpu_ce=0. On press it SHALL go to STEP regardless of run_sw, stepping past the breakpoint. The breakpoint SHALL NOT be evaluated in STEP.
REQ-024 Changing bkpt_addr or bkpt_en SHALL take effect at the next instr_done; it SHALL NOT retroactively trigger.
REQ-025 cpu_ce, halted and bkpt_hit SHALL be decoded from registered state only (glitch-free, no combinational path from inputs).
REQ-026 The debounce counter SHALL saturate at DEBOUNCE_CYCLES; width = clog2(DEBOUNCE_CYCLES+1).

Reset
REQ-027 RST=1 SHALL asynchronously force state=HALT, cpu_ce=0, halted=1, bkpt_hit=0, debounced key=1 (released), counter=0 and synchronizers=1 (run_sw synchronizer=0).
REQ-028 RST asserted mid-instruction SHALL drop cpu_ce immediately. After release the controller SHALL wait in HALT for a fresh press, and a key held through reset SHALL NOT produce press.

Structure
REQ-029 State codes and their width SHALL live in shared package xm23_pkg, alongside the existing CPU constants.
REQ-030 Synchronizer plus debouncer SHALL be sub-module key_debounce (ports CLOCK_50, RST, key_n, level, fall_pulse), reusable for KEY[3:1].

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Bounce step_key 0/1 every 2 cycles for 20 cycles, then hold 0 for 6 cycles -> exactly one press, state HALT->STEP.
REQ-032 run_sw=0, press, instr_done pulsed 5 cycles later -> cpu_ce=1 for exactly 6 cycles, then HALT with halted=1.
REQ-033 run_sw=1, bkpt_en=1, bkpt_addr=0x0010, press, instr_done with pc=0x000E then 0x0010 -> BREAK after the second pulse, cpu_ce=0, bkpt_hit=1. Next press -> STEP, one instruction, then HALT.
REQ-034 In RUN, drop run_sw, instr_done 3 cycles later with pc==bkpt_addr and bkpt_en=1 -> BREAK, not HALT. cpu_ce stays 1 until that instr_done.
REQ-035 Assert RST for 1 cycle during STEP while key held low -> cpu_ce=0 same cycle, HALT. No press until key is released and pressed again.
